// File: rtl/exe_pkg.sv
// Shared constants for the multi-cycle execute stage.
// Bus geometry, field offsets, size encodings and divider op bits.
package exe_pkg;

  localparam int DS_CTL_W = 29;
  localparam int ES_CTL_W = 14;

  function automatic int ds_bus_w(int xlen);
    return 4 * xlen + DS_CTL_W;
  endfunction

  function automatic int es_bus_w(int xlen);
    return 2 * xlen + ES_CTL_W;
  endfunction

  // Offsets inside the 29-bit control block of the ID->EX bus
  localparam int O_DEST   = 0;
  localparam int O_SEXT   = 5;
  localparam int O_SIZE   = 6;
  localparam int O_RFM    = 8;
  localparam int O_MWE    = 9;
  localparam int O_GRWE   = 10;
  localparam int O_S2_4   = 11;
  localparam int O_S2_IMM = 12;
  localparam int O_S1_PC  = 13;
  localparam int O_DIV    = 14;
  localparam int O_ALU    = 17;

  localparam int DIV_SGN = 0;
  localparam int DIV_MOD = 1;
  localparam int DIV_EN  = 2;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    D_IDLE,
    D_RUN,
    D_DONE
  } div_st_e;

  function automatic logic [7:0] byte_mask(logic [1:0] size);
    case (size)
      MEM_B:   return 8'h01;
      MEM_H:   return 8'h03;
      MEM_W:   return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(logic [1:0] size);
    case (size)
      MEM_B:   return 3'b000;
      MEM_H:   return 3'b001;
      MEM_W:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU with one-hot operation select.
// Shared by the execute stage for arithmetic and address generation.
module alu
  import exe_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic [11:0]     i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);
  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] w_sh;
  assign w_sh = i_b[SW-1:0];

  always_comb begin
    o_y = '0;
    unique case (1'b1)
      i_op[ALU_ADD]:  o_y = i_a + i_b;
      i_op[ALU_SUB]:  o_y = i_a - i_b;
      i_op[ALU_SLT]:  o_y = XLEN'($signed(i_a) < $signed(i_b));
      i_op[ALU_SLTU]: o_y = XLEN'(i_a < i_b);
      i_op[ALU_AND]:  o_y = i_a & i_b;
      i_op[ALU_NOR]:  o_y = ~(i_a | i_b);
      i_op[ALU_OR]:   o_y = i_a | i_b;
      i_op[ALU_XOR]:  o_y = i_a ^ i_b;
      i_op[ALU_SLL]:  o_y = i_a << w_sh;
      i_op[ALU_SRL]:  o_y = i_a >> w_sh;
      i_op[ALU_SRA]:  o_y = $signed(i_a) >>> w_sh;
      i_op[ALU_LUI]:  o_y = i_b;
      default:        o_y = '0;
    endcase
  end

endmodule

// File: rtl/exe_divider.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Works on magnitudes; signs are restored on the held result.
module exe_divider
  import exe_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_ack,
  input  logic            i_sgn,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  div_st_e r_st;
  div_st_e w_st_nx;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0] r_cnt;
  logic r_qneg;
  logic r_rneg;
  logic r_dz;
  logic w_sa;
  logic w_sb;
  logic [XLEN-1:0] w_ma;
  logic [XLEN-1:0] w_mb;
  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_diff;

  assign w_sa = i_sgn & i_a[XLEN-1];
  assign w_sb = i_sgn & i_b[XLEN-1];
  assign w_ma = w_sa ? -i_a : i_a;
  assign w_mb = w_sb ? -i_b : i_b;
  assign w_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_dvs};

  always_comb begin
    w_st_nx = r_st;
    unique case (r_st)
      D_IDLE:  if (i_start) w_st_nx = D_RUN;
      D_RUN:   if (r_cnt == LAST) w_st_nx = D_DONE;
      D_DONE:  if (i_ack) w_st_nx = D_IDLE;
      default: w_st_nx = D_IDLE;
    endcase
    if (i_abort) w_st_nx = D_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= D_IDLE;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_st <= w_st_nx;
      if (r_st == D_IDLE && i_start) begin
        r_quo  <= w_ma;
        r_rem  <= '0;
        r_dvs  <= w_mb;
        r_cnt  <= '0;
        r_qneg <= w_sa ^ w_sb;
        r_rneg <= w_sa;
        r_dz   <= (i_b == '0);
      end else if (r_st == D_RUN) begin
        r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
        r_rem <= w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Zero divisor leaves rem = |a|, so the sign fixup returns the dividend
  assign o_busy = (r_st == D_RUN);
  assign o_done = (r_st == D_DONE);
  assign o_quo  = r_dz ? '1 : (r_qneg ? -r_quo : r_quo);
  assign o_rem  = r_rneg ? -r_rem : r_rem;

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: one-cycle ALU, stalling divider, sub-word stores,
// misalignment detection, flush and result forwarding.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DS_BUS_W = ds_bus_w(XLEN),
  parameter int ES_BUS_W = es_bus_w(XLEN)
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                ds_to_es_valid,
  output logic                es_allow_in,
  input  logic [DS_BUS_W-1:0] ds_es_bus,
  input  logic                ms_allow_in,
  output logic                es_to_ms_valid,
  output logic [ES_BUS_W-1:0] es_ms_bus,
  input  logic                es_flush,
  output logic                es_busy,
  output logic                data_sram_en,
  output logic [XLEN/8-1:0]   data_sram_we,
  output logic [XLEN-1:0]     data_sram_addr,
  output logic [XLEN-1:0]     data_sram_wdata,
  output logic [4:0]          es_dest_reg,
  output logic                es_load,
  output logic                es_fwd_valid,
  output logic [XLEN-1:0]     es_fwd_data
);
  localparam int NB = XLEN / 8;

  logic r_valid;
  logic [DS_BUS_W-1:0] r_bus;

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rj;
  logic [XLEN-1:0] w_rkd;
  logic [DS_CTL_W-1:0] w_ctl;
  logic [11:0] w_aop;
  logic [2:0] w_dop;
  logic [4:0] w_dest;
  logic [1:0] w_size;
  logic w_sext;
  logic w_rfm;
  logic w_mwe;
  logic w_grwe;
  logic w_div_en;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_result;
  logic w_div_done;
  logic w_ready_go;
  logic w_mem;
  logic w_ale;
  logic [2:0] w_off;

  assign {w_pc, w_ctl, w_imm, w_rj, w_rkd} = r_bus;
  assign w_aop    = w_ctl[O_ALU +: 12];
  assign w_dop    = w_ctl[O_DIV +: 3];
  assign w_dest   = w_ctl[O_DEST +: 5];
  assign w_size   = w_ctl[O_SIZE +: 2];
  assign w_sext   = w_ctl[O_SEXT];
  assign w_rfm    = w_ctl[O_RFM];
  assign w_mwe    = w_ctl[O_MWE];
  assign w_grwe   = w_ctl[O_GRWE];
  assign w_div_en = w_dop[DIV_EN];

  assign w_src1 = w_ctl[O_S1_PC] ? w_pc : w_rj;
  assign w_src2 = w_ctl[O_S2_IMM] ? w_imm :
                  (w_ctl[O_S2_4] ? XLEN'(4) : w_rkd);

  alu #(.XLEN(XLEN)) u_alu (
    .i_op (w_aop),
    .i_a  (w_src1),
    .i_b  (w_src2),
    .o_y  (w_alu)
  );

  exe_divider #(.XLEN(XLEN)) u_div (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (r_valid && w_div_en),
    .i_abort (es_flush),
    .i_ack   (es_to_ms_valid && ms_allow_in),
    .i_sgn   (w_dop[DIV_SGN]),
    .i_a     (w_rj),
    .i_b     (w_rkd),
    .o_busy  (es_busy),
    .o_done  (w_div_done),
    .o_quo   (w_quo),
    .o_rem   (w_rem)
  );

  assign w_result = w_div_en ? (w_dop[DIV_MOD] ? w_rem : w_quo) : w_alu;
  assign w_ready_go = w_div_en ? w_div_done : 1'b1;

  assign es_allow_in    = !r_valid || (w_ready_go && ms_allow_in);
  assign es_to_ms_valid = r_valid && w_ready_go && !es_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
    end else begin
      if (es_flush) r_valid <= 1'b0;
      else if (es_allow_in) r_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allow_in) r_bus <= ds_es_bus;
    end
  end

  assign w_mem = w_mwe || w_rfm;
  assign w_ale = w_mem && ((w_alu[2:0] & align_mask(w_size)) != 3'b000);
  assign w_off = w_alu[2:0] & ((XLEN == 64) ? 3'b111 : 3'b011);

  assign data_sram_en = r_valid && w_mem && !w_ale && w_ready_go
                        && ms_allow_in && !es_flush;
  assign data_sram_we = (w_mwe && data_sram_en)
                        ? (NB'(byte_mask(w_size)) << w_off) : '0;
  assign data_sram_addr = w_alu;

  always_comb begin
    data_sram_wdata = w_rkd;
    case (w_size)
      MEM_B: data_sram_wdata = {(XLEN/8){w_rkd[7:0]}};
      MEM_H: data_sram_wdata = {(XLEN/16){w_rkd[15:0]}};
      MEM_W: data_sram_wdata = {(XLEN/32){w_rkd[31:0]}};
      MEM_D: data_sram_wdata = w_rkd;
      default: data_sram_wdata = w_rkd;
    endcase
  end

  assign es_ms_bus = {w_pc, w_grwe, w_dest, w_result, w_rfm,
                      w_size, w_sext, w_alu[2:0], w_ale};

  assign es_dest_reg  = r_valid ? w_dest : 5'd0;
  assign es_load      = r_valid && w_rfm;
  assign es_fwd_valid = r_valid && w_grwe && !w_rfm && w_ready_go;
  assign es_fwd_data  = w_result;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc (XLEN=32).
// Each scenario task drives vectors and compares against hand values.
module tb_exe_stage_mc;

  localparam int DSW = 157;
  localparam int ESW = 78;

  logic clk;
  logic reset;
  logic ds_to_es_valid;
  logic es_allow_in;
  logic [DSW-1:0] ds_es_bus;
  logic ms_allow_in;
  logic es_to_ms_valid;
  logic [ESW-1:0] es_ms_bus;
  logic es_flush;
  logic es_busy;
  logic data_sram_en;
  logic [3:0] data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [4:0] es_dest_reg;
  logic es_load;
  logic es_fwd_valid;
  logic [31:0] es_fwd_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] ms_res;
  logic ms_ale;
  assign ms_res = es_ms_bus[39:8];
  assign ms_ale = es_ms_bus[0];

  exe_stage_mc dut (
    .clk             (clk),
    .reset           (reset),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allow_in     (es_allow_in),
    .ds_es_bus       (ds_es_bus),
    .ms_allow_in     (ms_allow_in),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_ms_bus       (es_ms_bus),
    .es_flush        (es_flush),
    .es_busy         (es_busy),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .es_dest_reg     (es_dest_reg),
    .es_load         (es_load),
    .es_fwd_valid    (es_fwd_valid),
    .es_fwd_data     (es_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DSW-1:0] mk(
    input logic [31:0] pc, input logic [11:0] aop, input logic [2:0] dop,
    input logic s1pc, input logic s2imm, input logic s24,
    input logic grwe, input logic mwe, input logic rfm,
    input logic [1:0] sz, input logic [4:0] dest,
    input logic [31:0] imm, input logic [31:0] rj, input logic [31:0] rkd);
    return {pc, aop, dop, s1pc, s2imm, s24, grwe, mwe, rfm,
            sz, 1'b0, dest, imm, rj, rkd};
  endfunction

  // Present one instruction; returns 2 time units after the capturing edge
  task automatic issue(input logic [DSW-1:0] b);
    ds_es_bus = b;
    ds_to_es_valid = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ds_to_es_valid = 1'b0;
    ds_es_bus = '0;
    ms_allow_in = 1'b1;
    es_flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (es_allow_in !== 1'b1) begin errors++;
      $display("FAIL rst_allow_in: got %b want 1", es_allow_in); end
    checks++; if (es_to_ms_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %b want 0", es_to_ms_valid); end
    checks++; if (es_ms_bus !== '0) begin errors++;
      $display("FAIL rst_bus: got %h want 0", es_ms_bus); end
    checks++; if ({data_sram_en, data_sram_we, es_busy, es_dest_reg,
                   es_load, es_fwd_valid} !== 13'd0) begin errors++;
      $display("FAIL rst_ctrl: got en=%b we=%b busy=%b dest=%0d",
               data_sram_en, data_sram_we, es_busy, es_dest_reg); end
    checks++; if ({data_sram_addr, data_sram_wdata, es_fwd_data} !== 96'd0)
    begin errors++;
      $display("FAIL rst_data: got addr=%h wdata=%h fwd=%h want 0",
               data_sram_addr, data_sram_wdata, es_fwd_data); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_alu;
    issue(mk(32'h1c000000, 12'h001, 3'b000, 0, 0, 0, 1, 0, 0,
             2'd0, 5'd3, 32'h0, 32'd5, 32'd7));
    checks++; if (es_to_ms_valid !== 1'b1) begin errors++;
      $display("FAIL add_valid: got %b want 1", es_to_ms_valid); end
    checks++; if (ms_res !== 32'd12) begin errors++;
      $display("FAIL add_result: got %h want 0000000c", ms_res); end
    checks++; if (es_fwd_valid !== 1'b1 || es_fwd_data !== 32'd12) begin
      errors++;
      $display("FAIL add_fwd: got v=%b d=%h want v=1 d=0000000c",
               es_fwd_valid, es_fwd_data); end
    checks++; if (es_dest_reg !== 5'd3 || data_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL add_dest_en: got dest=%0d en=%b want 3 0",
               es_dest_reg, data_sram_en); end
    issue(mk(32'h1c000010, 12'h001, 3'b000, 1, 0, 1, 1, 0, 0,
             2'd0, 5'd1, 32'h0, 32'h0, 32'h0));
    checks++; if (ms_res !== 32'h1c000014) begin errors++;
      $display("FAIL pc_plus4: got %h want 1c000014", ms_res); end
    @(posedge clk); #2;
    checks++; if (es_to_ms_valid !== 1'b0 || es_dest_reg !== 5'd0) begin
      errors++;
      $display("FAIL alu_drain: got v=%b dest=%0d want 0 0",
               es_to_ms_valid, es_dest_reg); end
  endtask

  task automatic test_back_to_back;
    issue(mk(32'h1c000020, 12'h002, 3'b000, 0, 1, 0, 1, 0, 0,
             2'd0, 5'd5, 32'd7, 32'd5, 32'd0));
    checks++; if (ms_res !== 32'hfffffffe) begin errors++;
      $display("FAIL b2b_sub: got %h want fffffffe", ms_res); end
    issue(mk(32'h1c000024, 12'h008, 3'b000, 0, 0, 0, 1, 0, 0,
             2'd0, 5'd6, 32'd0, 32'd3, 32'hfffffff0));
    checks++; if (es_to_ms_valid !== 1'b1 || ms_res !== 32'd1) begin
      errors++;
      $display("FAIL b2b_sltu: got v=%b res=%h want 1 00000001",
               es_to_ms_valid, ms_res); end
    @(posedge clk); #2;
  endtask

  task automatic run_div(input string nm, input logic [2:0] dop,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int lat;
    int nb;
    lat = 0;
    nb = 0;
    issue(mk(32'h1c000100, 12'h000, dop, 0, 0, 0, 1, 0, 0,
             2'd0, 5'd7, 32'h0, a, b));
    while (es_to_ms_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #2;
      lat++;
      if (es_busy === 1'b1) nb++;
    end
    checks++; if (lat != 33) begin errors++;
      $display("FAIL %s_latency: got %0d want 33", nm, lat); end
    checks++; if (nb != 32) begin errors++;
      $display("FAIL %s_busy: got %0d want 32", nm, nb); end
    checks++; if (ms_res !== exp || es_fwd_data !== exp) begin errors++;
      $display("FAIL %s_result: got %h fwd %h want %h",
               nm, ms_res, es_fwd_data, exp); end
    @(posedge clk); #2;
  endtask

  task automatic test_div;
    run_div("sdiv", 3'b101, 32'hfffffff9, 32'd2, 32'hfffffffd);
    run_div("smod", 3'b111, 32'hfffffff9, 32'd2, 32'hffffffff);
    run_div("div0", 3'b101, 32'hfffffff9, 32'd0, 32'hffffffff);
    run_div("mod0", 3'b111, 32'hfffffff9, 32'd0, 32'hfffffff9);
    run_div("udiv", 3'b100, 32'd100, 32'd7, 32'd14);
    run_div("umod", 3'b110, 32'd100, 32'd7, 32'd2);
    run_div("minm1", 3'b101, 32'h80000000, 32'hffffffff, 32'h80000000);
    run_div("minm1_mod", 3'b111, 32'h80000000, 32'hffffffff, 32'd0);
  endtask

  task automatic test_store_byte;
    issue(mk(32'h1c000200, 12'h001, 3'b000, 0, 1, 0, 0, 1, 0,
             2'd0, 5'd0, 32'd3, 32'h1000, 32'h000000ab));
    checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1000) begin
      errors++;
      $display("FAIL sb_en_we: got en=%b we=%b want 1 1000",
               data_sram_en, data_sram_we); end
    checks++; if (data_sram_wdata !== 32'habababab ||
                  data_sram_addr !== 32'h1003) begin errors++;
      $display("FAIL sb_data: got wdata=%h addr=%h want abababab 1003",
               data_sram_wdata, data_sram_addr); end
    @(posedge clk); #2;
    checks++; if (data_sram_en !== 1'b0) begin errors++;
      $display("FAIL sb_once: got en=%b want 0", data_sram_en); end
  endtask

  task automatic test_misaligned;
    issue(mk(32'h1c000300, 12'h001, 3'b000, 0, 1, 0, 0, 1, 0,
             2'd2, 5'd0, 32'd2, 32'h1000, 32'h12345678));
    checks++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'b0000 ||
                  ms_ale !== 1'b1) begin errors++;
      $display("FAIL sw_ale: got en=%b we=%b ale=%b want 0 0000 1",
               data_sram_en, data_sram_we, ms_ale); end
    issue(mk(32'h1c000304, 12'h001, 3'b000, 0, 1, 0, 0, 1, 0,
             2'd1, 5'd0, 32'd2, 32'h1000, 32'h00001234));
    checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1100 ||
                  ms_ale !== 1'b0) begin errors++;
      $display("FAIL sh_we: got en=%b we=%b ale=%b want 1 1100 0",
               data_sram_en, data_sram_we, ms_ale); end
    checks++; if (data_sram_wdata !== 32'h12341234) begin errors++;
      $display("FAIL sh_wdata: got %h want 12341234", data_sram_wdata); end
    issue(mk(32'h1c000308, 12'h001, 3'b000, 0, 1, 0, 1, 0, 1,
             2'd2, 5'd4, 32'd4, 32'h1000, 32'h0));
    checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b0000 ||
                  es_load !== 1'b1 || es_fwd_valid !== 1'b0) begin errors++;
      $display("FAIL lw: got en=%b we=%b load=%b fwd=%b want 1 0000 1 0",
               data_sram_en, data_sram_we, es_load, es_fwd_valid); end
    @(posedge clk); #2;
  endtask

  task automatic test_backpressure;
    logic [ESW-1:0] exp_bus;
    exp_bus = {32'h1c000400, 1'b0, 5'd0, 32'h00001008, 1'b0, 2'd2,
               1'b0, 3'd0, 1'b0};
    ms_allow_in = 1'b0;
    issue(mk(32'h1c000400, 12'h001, 3'b000, 0, 1, 0, 0, 1, 0,
             2'd2, 5'd0, 32'd8, 32'h1000, 32'hdeadbeef));
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_sram_en !== 1'b0 || es_allow_in !== 1'b0 ||
                    es_ms_bus !== exp_bus) begin errors++;
        $display("FAIL bp_hold%0d: got en=%b allow=%b bus=%h want 0 0 %h",
                 i, data_sram_en, es_allow_in, es_ms_bus, exp_bus); end
      @(posedge clk); #2;
    end
    ms_allow_in = 1'b1;
    #1;
    checks++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1111 ||
                  data_sram_wdata !== 32'hdeadbeef) begin errors++;
      $display("FAIL bp_release: got en=%b we=%b wdata=%h",
               data_sram_en, data_sram_we, data_sram_wdata); end
    @(posedge clk); #2;
    checks++; if (data_sram_en !== 1'b0 || es_to_ms_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: got en=%b v=%b want 0 0",
               data_sram_en, es_to_ms_valid); end
  endtask

  task automatic test_flush;
    issue(mk(32'h1c000500, 12'h000, 3'b100, 0, 0, 0, 1, 0, 0,
             2'd0, 5'd9, 32'h0, 32'd100, 32'd7));
    repeat (10) begin @(posedge clk); #2; end
    es_flush = 1'b1;
    #1;
    checks++; if (es_to_ms_valid !== 1'b0 || es_busy !== 1'b1) begin
      errors++;
      $display("FAIL fl_during: got v=%b busy=%b want 0 1",
               es_to_ms_valid, es_busy); end
    @(posedge clk); #1;
    es_flush = 1'b0;
    #1;
    checks++; if (es_busy !== 1'b0 || es_allow_in !== 1'b1 ||
                  es_dest_reg !== 5'd0) begin errors++;
      $display("FAIL fl_after: got busy=%b allow=%b dest=%0d want 0 1 0",
               es_busy, es_allow_in, es_dest_reg); end
    run_div("post_flush", 3'b100, 32'd100, 32'd7, 32'd14);
    issue(mk(32'h1c000510, 12'h001, 3'b000, 0, 1, 0, 0, 1, 0,
             2'd2, 5'd0, 32'd16, 32'h1000, 32'h55));
    es_flush = 1'b1;
    ds_es_bus = mk(32'h1c000514, 12'h001, 3'b000, 0, 0, 0, 1, 0, 0,
                   2'd0, 5'd11, 32'h0, 32'd1, 32'd1);
    ds_to_es_valid = 1'b1;
    #1;
    checks++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'b0000) begin
      errors++;
      $display("FAIL fl_store: got en=%b we=%b want 0 0000",
               data_sram_en, data_sram_we); end
    @(posedge clk); #1;
    es_flush = 1'b0;
    ds_to_es_valid = 1'b0;
    #1;
    checks++; if (es_to_ms_valid !== 1'b0 || es_dest_reg !== 5'd0) begin
      errors++;
      $display("FAIL fl_drop: got v=%b dest=%0d want 0 0",
               es_to_ms_valid, es_dest_reg); end
  endtask

  task automatic test_async_reset;
    issue(mk(32'h1c000600, 12'h000, 3'b101, 0, 0, 0, 1, 0, 0,
             2'd0, 5'd12, 32'h0, 32'd50, 32'd3));
    repeat (5) @(posedge clk);
    #3;
    checks++; if (es_busy !== 1'b1) begin errors++;
      $display("FAIL ar_pre: got busy=%b want 1", es_busy); end
    reset = 1'b0;
    #1;
    checks++; if (es_busy !== 1'b0 || es_to_ms_valid !== 1'b0 ||
                  es_allow_in !== 1'b1 || es_ms_bus !== '0 ||
                  es_dest_reg !== 5'd0) begin errors++;
      $display("FAIL ar_clear: got busy=%b v=%b allow=%b bus=%h",
               es_busy, es_to_ms_valid, es_allow_in, es_ms_bus); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    run_div("post_reset", 3'b101, 32'd50, 32'hfffffffd, 32'hfffffff0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_div();
    test_store_byte();
    test_misaligned();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
